// File: rtl/cmpgen_pkg.sv
// Shared types and helpers for the compressor generator datapath blocks.
package cmpgen_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Bit-counter width for a WIDTH-bit word; kept at least one bit wide.
    function automatic int CNT_W(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/result_serializer.sv
// Parallel-in, serial-out converter for compressor results: LSB-first, one bit per
// accepted serial beat, with a one-word holding buffer so consecutive words stream gap-free.
module result_serializer
    import cmpgen_pkg::*;
#(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] par_data,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             ser_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int             CW       = CNT_W(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;

    logic accept;
    logic beat;
    logic last_bit;

    assign par_ready = !hold_full_q;
    assign accept    = par_valid && !hold_full_q;
    assign ser_valid = (state_q == SHIFT);
    assign last_bit  = (cnt_q == LAST_CNT);
    assign beat      = ser_valid && ser_ready;
    // Gate with ser_valid so idle outputs read as zero rather than stale shifter contents.
    assign ser_data  = ser_valid && sr_q[0];
    assign ser_last  = ser_valid && last_bit;
    assign busy      = ser_valid || hold_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = par_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (beat && last_bit) begin
                    // Reload on the last beat so the next word's bit 0 follows without a bubble.
                    if (hold_full_q) begin
                        sr_d        = hold_q;
                        cnt_d       = '0;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        sr_d  = par_data;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (beat) begin
                        sr_d  = sr_q >> 1;
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (accept) begin
                        hold_d      = par_data;
                        hold_full_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_result_serializer.sv
// Directed and scoreboard bench for result_serializer.
module tb_result_serializer;

    localparam int W = 21;

    logic         clk;
    logic         rst;
    logic [W-1:0] par_data;
    logic         par_valid;
    logic         par_ready;
    logic         ser_data;
    logic         ser_valid;
    logic         ser_ready;
    logic         ser_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    int          rdy_mode   = 0;
    logic        rdy_manual = 1'b0;
    logic        rdy_gen    = 1'b0;
    logic [31:0] pat        = 32'h9B3D_6E57;
    int          pidx       = 0;

    logic [W-1:0] exp_q[$];
    int           rx_words = 0;
    int           bitcnt   = 0;
    logic [W-1:0] rx_word  = '0;
    logic         stall_v  = 1'b0;
    logic         st_d     = 1'b0;
    logic         st_l     = 1'b0;

    result_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .par_data  (par_data),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ser_ready = (rdy_mode == 0) ? rdy_manual : rdy_gen;

    always begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) begin
            rdy_gen = pat[pidx[4:0]];
            pidx    = (pidx + 1) % 32;
        end else begin
            rdy_gen = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial-side monitor: rebuilds words, checks beat count, stall stability and order.
    always @(negedge clk) begin
        if (rst) begin
            bitcnt  = 0;
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                chk("stall_valid", ser_valid, 1'b1);
                chk("stall_data", ser_data, st_d);
                chk("stall_last", ser_last, st_l);
            end
            stall_v = ser_valid && !ser_ready;
            st_d    = ser_data;
            st_l    = ser_last;
            if (ser_valid && ser_ready) begin
                rx_word = {ser_data, rx_word[W-1:1]};
                bitcnt++;
                if (ser_last) begin
                    chk("beats", bitcnt, W);
                    if (exp_q.size() == 0) chk("extra_word", 1, 0);
                    else chk("word", rx_word, exp_q.pop_front());
                    rx_words++;
                    bitcnt = 0;
                end else if (bitcnt >= W) begin
                    chk("no_last", 0, 1);
                    bitcnt = 0;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] w);
        int n;
        n         = 0;
        par_data  = w;
        par_valid = 1'b1;
        @(negedge clk);
        while (!par_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (!par_ready) chk("accept_timeout", 0, 1);
        else exp_q.push_back(w);
        @(posedge clk);
        #1;
        par_valid = 1'b0;
        par_data  = W'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("idle_timeout", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int           base;
        int           run;
        int           nlast;
        int           lp0;
        int           lp1;
        int           n;
        logic [W-1:0] rw;

        rst       = 1'b1;
        par_valid = 1'b0;
        par_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", ser_valid, 0);
        chk("rst_data", ser_data, 0);
        chk("rst_last", ser_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", par_ready, 1);
        @(posedge clk);
        #1;

        // Single word, ready always high
        rdy_manual = 1'b1;
        base = rx_words;
        send(21'h155555);
        @(negedge clk);
        chk("t1_lat_valid", ser_valid, 1);
        chk("t1_lat_data", ser_data, 1);
        chk("t1_lat_last", ser_last, 0);
        wait_idle();
        chk("t1_words", rx_words - base, 1);
        chk("t1_idle_valid", ser_valid, 0);
        chk("t1_idle_ready", par_ready, 1);

        // Two words back to back, no bubble
        base  = rx_words;
        send(21'h000001);
        run   = 0;
        nlast = 0;
        lp0   = 0;
        lp1   = 0;
        fork
            send(21'h100000);
            begin
                @(negedge clk);
                while (ser_valid && run < 100) begin
                    run++;
                    if (ser_last) begin
                        if (nlast == 0) lp0 = run;
                        else lp1 = run;
                        nlast++;
                    end
                    @(negedge clk);
                end
            end
        join
        wait_idle();
        chk("t2_run", run, 42);
        chk("t2_nlast", nlast, 2);
        chk("t2_last0", lp0, 21);
        chk("t2_last1", lp1, 42);
        chk("t2_words", rx_words - base, 2);

        // Toggling ser_ready pattern
        base     = rx_words;
        rdy_mode = 1;
        send(21'h0ABCDE);
        wait_idle();
        rdy_mode = 0;
        chk("t3_words", rx_words - base, 1);

        // Shifter and hold full, third word stalls
        base       = rx_words;
        rdy_manual = 1'b0;
        send(21'h0F0F0F);
        send(21'h1234AB);
        par_data  = 21'h0C0C0C;
        par_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_ready_full", par_ready, 0);
        chk("t4_busy", busy, 1);
        @(posedge clk);
        #1;
        rdy_manual = 1'b1;
        n = 0;
        @(negedge clk);
        while (!par_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("t4_wait", n, 21);
        exp_q.push_back(21'h0C0C0C);
        @(posedge clk);
        #1;
        par_valid = 1'b0;
        wait_idle();
        chk("t4_words", rx_words - base, 3);
        chk("t4_exp_empty", exp_q.size(), 0);

        // Reset mid-word
        base = rx_words;
        send(21'h1FFFFF);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t5_valid", ser_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", par_ready, 1);
        chk("t5_data", ser_data, 0);
        chk("t5_last", ser_last, 0);
        chk("t5_dropped", rx_words - base, 0);
        @(posedge clk);
        #1;
        send(21'h000003);
        wait_idle();
        chk("t5_words", rx_words - base, 1);

        // Random scoreboard run
        base     = rx_words;
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            rw = W'($urandom);
            send(rw);
        end
        wait_idle();
        rdy_mode = 0;
        chk("t6_words", rx_words - base, 1000);
        chk("t6_exp_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
